// File: rtl/sigmul_pkg.sv
// Shared types and constants for the sequential significand multiplier.
package sigmul_pkg;

    localparam int NSIG_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold 0..NSIG.
    function automatic int cnt_width(input int nsig);
        return $clog2(nsig + 1);
    endfunction

endpackage

// File: rtl/sigmul_seq_if.sv
// Operand/product handshake bundle between the unpack front end and the multiplier.
interface sigmul_seq_if
    import sigmul_pkg::*;
#(
    parameter int NSIG = NSIG_DEFAULT
);
    logic              in_valid;
    logic              in_ready;
    logic [NSIG:0]     a;
    logic [NSIG:0]     b;
    logic              out_valid;
    logic              out_ready;
    logic [2*NSIG+1:0] p;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/sigmul_step.sv
// One shift-add step: upper half of the partial product plus a conditional multiplicand.
module sigmul_step
    import sigmul_pkg::*;
#(
    parameter int NSIG = NSIG_DEFAULT
) (
    input  logic [NSIG:0]   upper,
    input  logic [NSIG:0]   multiplicand,
    input  logic            p_lsb,
    output logic [NSIG+1:0] sum
);
    logic [NSIG:0] addend_s;

    // Ripple-carry chain, same bit ordering as the array multiplier rows.
    always_comb begin
        logic carry_v;
        sum      = {(NSIG+2){1'b0}};
        addend_s = p_lsb ? multiplicand : {(NSIG+1){1'b0}};
        carry_v  = 1'b0;
        for (int i = 0; i <= NSIG; i++) begin
            sum[i]  = upper[i] ^ addend_s[i] ^ carry_v;
            carry_v = (upper[i] & addend_s[i]) | (carry_v & (upper[i] ^ addend_s[i]));
        end
        sum[NSIG+1] = carry_v;
    end

endmodule

// File: rtl/sigmul_seq.sv
// Sequential significand multiplier: NSIG+1 shift-add steps over one shared adder.
module sigmul_seq
    import sigmul_pkg::*;
#(
    parameter int NSIG = NSIG_DEFAULT
) (
    input logic        clk,
    input logic        rst,
    sigmul_seq_if.slave bus
);
    localparam int OW = NSIG + 1;
    localparam int PW = 2 * NSIG + 2;
    localparam int CW = cnt_width(NSIG);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSIG);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t          state_r;
    logic [OW-1:0]   a_r;
    logic [PW-1:0]   prod_r;
    logic [CW-1:0]   cnt_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;
    logic [NSIG+1:0] sum_s;

    sigmul_step #(.NSIG(NSIG)) u_step (
        .upper        (prod_r[PW-1:OW]),
        .multiplicand (a_r),
        .p_lsb        (prod_r[0]),
        .sum          (sum_s)
    );

    // Controller FSM; handshake flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= {OW{1'b0}};
            prod_r      <= {PW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.a;
                        prod_r     <= {{OW{1'b0}}, bus.b};
                        cnt_r      <= {CW{1'b0}};
                        state_r    <= MUL;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                MUL: begin
                    // Multiplier bits retire from the bottom as the sum enters the top.
                    prod_r <= {sum_s, prod_r[NSIG:1]};
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r <= MUL;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.p         = prod_r;

endmodule

// File: tb/tb_sigmul_seq.sv
// Scoreboard bench for sigmul_seq: directed vectors at NSIG=10 plus NSIG=4/23 sweeps.
module tb_sigmul_seq;
    import sigmul_pkg::*;

    localparam int NS = 10;
    localparam int W  = NS + 1;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    sigmul_seq_if #(.NSIG(NS)) bus();
    sigmul_seq #(.NSIG(NS)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    logic [PW-1:0] exp_q[$];
    int            acc_q[$];
    bit            prev_ov;
    bit            b2b = 1'b0;
    bit            have_last = 1'b0;
    int            last_acc = 0;
    logic          start_sweep = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event seen or bound expired, want none", name);
    endtask

    // Output monitor: latency on rising out_valid, product on handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov <= 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) begin
                if (acc_q.size() == 0) fail_now("spurious_valid");
                else check("latency", 64'(cyc - acc_q[0]), 64'(NS + 1));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_product");
                else begin
                    check("product", 64'(bus.p), 64'(exp_q.pop_front()));
                    void'(acc_q.pop_front());
                end
            end
            prev_ov <= bus.out_valid;
        end
    end

    // Present operands until accepted; expected product queued at acceptance.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [PW-1:0] ev, input bit hold);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        bus.a = av;
        bus.b = bv;
        bus.in_valid = 1'b1;
        while (!done && n < 64) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1'b1;
                exp_q.push_back(ev);
                acc_q.push_back(cyc + 1);
                if (b2b && have_last) check("accept_spacing", 64'(cyc + 1 - last_acc), 64'(NS + 3));
                last_acc = cyc + 1;
                have_last = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) fail_now("accept_timeout");
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] p;
    } vec_t;

    vec_t vecs[4] = '{
        '{11'h400, 11'h400, 22'h100000},
        '{11'h7FF, 11'h7FF, 22'h3FF001},
        '{11'h7FF, 11'h400, 22'h1FFC00},
        '{11'h000, 11'h7FF, 22'h000000}
    };

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int n;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_p", 64'(bus.p), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;

        // Directed vectors, one at a time; each must pulse out_valid once.
        for (int i = 0; i < 4; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);
            @(negedge clk);
            check("busy_in_mul", 64'(bus.busy), 64'd1);
            wait_empty();
            @(negedge clk);
            check("one_pulse", 64'(bus.out_valid), 64'd0);
            check("ready_after", 64'(bus.in_ready), 64'd1);
            @(posedge clk);
            #1;
        end

        // Back-pressure: result held 20 cycles, operand pulses ignored.
        bus.out_ready = 1'b0;
        issue(11'h123, 11'h456, 22'h04EDC2, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) fail_now("bp_valid_timeout");
        bus.a = 11'h7FF;
        bus.b = 11'h7FF;
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_p", 64'(bus.p), 64'h04EDC2);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            bus.in_valid = i[0];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_empty();
        @(negedge clk);
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Reset while cnt==5 discards the operation.
        issue(11'h7FF, 11'h7FF, 22'h3FF001, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_p", 64'(bus.p), 64'd0);
        @(posedge clk);
        #1;
        issue(11'h555, 11'h6AB, 22'h238DC7, 1'b0);
        wait_empty();
        @(posedge clk);
        #1;

        // Back-to-back random pairs, in_valid and out_ready held high.
        b2b = 1'b1;
        have_last = 1'b0;
        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            issue(ra, rb, PW'(ra) * PW'(rb), 1'b1);
        end
        bus.in_valid = 1'b0;
        wait_empty();
        b2b = 1'b0;

        start_sweep = 1'b1;
        n = 0;
        while (!(g_sweep[0].sdone && g_sweep[1].sdone) && n < 30000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_sweep[0].sdone && g_sweep[1].sdone)) fail_now("sweep_timeout");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Width sweeps: NSIG=4 exhaustive, NSIG=23 random.
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int SN    = (g == 0) ? 4 : 23;
        localparam int SW    = SN + 1;
        localparam int SPW   = 2 * SW;
        localparam int NPAIR = (g == 0) ? 1024 : 40;

        sigmul_seq_if #(.NSIG(SN)) sbus();
        sigmul_seq #(.NSIG(SN)) u_dut (.clk(clk), .rst(rst), .bus(sbus));

        logic [SPW-1:0] sexp_q[$];
        int             sacc_q[$];
        bit             sprev_ov;
        bit             sdone = 1'b0;

        always @(negedge clk) begin
            if (rst) begin
                sexp_q.delete();
                sacc_q.delete();
                sprev_ov <= 1'b0;
            end else begin
                if (sbus.out_valid && !sprev_ov) begin
                    if (sacc_q.size() == 0) fail_now("sweep_spurious_valid");
                    else check("sweep_latency", 64'(cyc - sacc_q[0]), 64'(SN + 1));
                end
                if (sbus.out_valid && sbus.out_ready) begin
                    if (sexp_q.size() == 0) fail_now("sweep_unexpected_product");
                    else begin
                        check("sweep_product", 64'(sbus.p), 64'(sexp_q.pop_front()));
                        void'(sacc_q.pop_front());
                    end
                end
                sprev_ov <= sbus.out_valid;
            end
        end

        initial begin
            logic [SW-1:0]  av;
            logic [SW-1:0]  bv;
            bit             done;
            int             n;
            sbus.in_valid = 1'b0;
            sbus.a = '0;
            sbus.b = '0;
            sbus.out_ready = 1'b0;
            wait (start_sweep);
            @(posedge clk);
            #1;
            sbus.out_ready = 1'b1;
            for (int k = 0; k < NPAIR; k++) begin
                if (g == 0) begin
                    av = SW'(k / 32);
                    bv = SW'(k % 32);
                end else begin
                    av = SW'($urandom);
                    bv = SW'($urandom);
                end
                sbus.a = av;
                sbus.b = bv;
                sbus.in_valid = 1'b1;
                done = 1'b0;
                n = 0;
                while (!done && n < 64) begin
                    @(negedge clk);
                    if (sbus.in_ready) begin
                        done = 1'b1;
                        sexp_q.push_back(SPW'(av) * SPW'(bv));
                        sacc_q.push_back(cyc + 1);
                    end
                    @(posedge clk);
                    #1;
                    n++;
                end
                if (!done) fail_now("sweep_accept_timeout");
            end
            sbus.in_valid = 1'b0;
            n = 0;
            while (sexp_q.size() != 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (sexp_q.size() != 0) fail_now("sweep_drain_timeout");
            sdone = 1'b1;
        end
    end

endmodule
